// File: rtl/image_writer_pkg.sv
// Shared definitions for the image-memory write/read ends: FSM encoding,
// coordinate width and the {R,G,B} pixel word layout.
package image_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_t;

  localparam int PIXEL_W = 24;
  localparam int COORD_W = 11;

  // Pixel word layout agreed between writer and reader: red in the MSBs.
  function automatic logic [PIXEL_W-1:0] pack_rgb(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/image_writer_raster_counter.sv
// Raster position tracker: x/y coordinates plus a linear address that is
// kept equal to x + width*y by incrementing alongside the coordinates.
module image_writer_raster_counter
  import image_writer_pkg::*;
#(
  parameter int p_width      = 80,
  parameter int p_height     = 480,
  parameter int p_addr_width = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load_one,
  input  logic                    step,
  output logic [COORD_W-1:0]      x,
  output logic [COORD_W-1:0]      y,
  output logic [p_addr_width-1:0] addr,
  output logic                    last,
  output logic                    at_origin
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(p_width - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(p_height - 1);

  assign last      = (x == X_MAX) && (y == Y_MAX);
  assign at_origin = (x == '0) && (y == '0);

  // Counter update: clear beats resync-load beats a normal step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (load_one) begin
      x    <= COORD_W'(1);
      y    <= '0;
      addr <= p_addr_width'(1);
    end else if (step) begin
      if (x == X_MAX) begin
        x <= '0;
        if (y == Y_MAX) begin
          y    <= '0;
          addr <= '0;
        end else begin
          y    <= y + COORD_W'(1);
          addr <= addr + p_addr_width'(1);
        end
      end else begin
        x    <= x + COORD_W'(1);
        addr <= addr + p_addr_width'(1);
      end
    end
  end

endmodule

// File: rtl/image_writer.sv
// Frame-buffer writer: takes a valid/ready RGB stream and writes one frame
// in raster order into the image RAM write port, one cycle after each
// accepted pixel.
module image_writer
  import image_writer_pkg::*;
#(
  parameter int p_image_width  = 80,
  parameter int p_image_height = 480,
  parameter int p_addr_width   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [7:0]              in_R,
  input  logic [7:0]              in_G,
  input  logic [7:0]              in_B,
  output logic                    wr_en,
  output logic [p_addr_width-1:0] wr_addr,
  output logic [PIXEL_W-1:0]      wr_data,
  output logic [COORD_W-1:0]      pixel_x,
  output logic [COORD_W-1:0]      pixel_y,
  output logic                    busy,
  output logic                    done,
  output logic                    sync_err
);

  wr_state_t state_reg, state_next;

  logic                    hs;
  logic                    resync;
  logic                    arm;
  logic                    last;
  logic                    at_origin;
  logic [p_addr_width-1:0] addr;

  assign in_ready = (state_reg == ST_WRITE);
  assign busy     = (state_reg == ST_WRITE);
  assign done     = (state_reg == ST_DONE);
  assign hs       = in_valid & in_ready;
  // A start-of-frame marker anywhere but the origin restarts the frame.
  assign resync   = hs & in_sof & ~at_origin;
  assign arm      = (state_reg == ST_IDLE) & start & ~abort;

  image_writer_raster_counter #(
    .p_width      (p_image_width),
    .p_height     (p_image_height),
    .p_addr_width (p_addr_width)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .clear     (arm),
    .load_one  (resync),
    .step      (hs),
    .x         (pixel_x),
    .y         (pixel_y),
    .addr      (addr),
    .last      (last),
    .at_origin (at_origin)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; abort overrides both arming and frame completion.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (arm) state_next = ST_WRITE;
      ST_WRITE: begin
        if (abort)                      state_next = ST_IDLE;
        else if (hs && last && !resync) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // RAM write port: every accepted pixel is written exactly one cycle later,
  // including one accepted in the abort cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= hs;
      if (hs) begin
        wr_addr <= resync ? '0 : addr;
        wr_data <= pack_rgb(in_R, in_G, in_B);
      end
    end
  end

  // Sticky frame-sync error, cleared when a new frame is armed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      sync_err <= 1'b0;
    else if (arm)    sync_err <= 1'b0;
    else if (resync) sync_err <= 1'b1;
  end

endmodule
